rv_gpio: RTL and testbench

//  Parametrised memory-mapped GPIO: NBIT-wide bidirectional port with per-bit direction,

---
 rtl/rv_gpio_pkg.sv | 25 ++
 rtl/rv_gpio_if.sv | 16 +
 rtl/rv_sync.sv | 24 ++
 rtl/rv_gpio.sv | 139 +++++++++++++
 tb/tb_rv_gpio.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_gpio_pkg.sv
// Shared types, register selectors and helpers for the rv_gpio block.
package rv_gpio_pkg;

    typedef logic [31:0] u32_t;

    // Word index within the 32-byte window (adr[4:2]).
    typedef enum logic [2:0] {
        GPIO_OUT  = 3'd0,
        GPIO_IN   = 3'd1,
        GPIO_DIR  = 3'd2,
        GPIO_SET  = 3'd3,
        GPIO_CLR  = 3'd4,
        GPIO_RISE = 3'd5,
        GPIO_FALL = 3'd6,
        GPIO_PEND = 3'd7
    } gpio_reg_e;

    function automatic u32_t width_mask(input int nbit);
        if (nbit >= 32) begin
            return '1;
        end
        return u32_t'((64'd1 << nbit) - 64'd1);
    endfunction

endpackage

// File: rtl/rv_gpio_if.sv
// Data-bus slice seen by rv_gpio: address, qualifiers, byte enables and data.
interface rv_gpio_if;
    import rv_gpio_pkg::*;

    logic [4:0] adr;
    logic       cs;
    logic       rdy;
    logic [3:0] we;
    logic       re;
    u32_t       dw;
    u32_t       dr;

    modport master (output adr, cs, rdy, we, re, dw, input dr);
    modport slave  (input adr, cs, rdy, we, re, dw, output dr);

endinterface

// File: rtl/rv_sync.sv
// W-bit multi-flop synchroniser for asynchronous pad inputs, cleared by reset.
module rv_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES*W-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[(STAGES-1)*W-1:0], d};
        end
    end

    assign q = chain_reg[STAGES*W-1 -: W];

endmodule

// File: rtl/rv_gpio.sv
// Memory-mapped GPIO: per-bit direction, atomic set/clear, synchronised inputs
// and rise/fall edge interrupts with write-one-to-clear pending bits.
module rv_gpio
    import rv_gpio_pkg::*;
#(
    parameter int              NBIT        = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [NBIT-1:0] OUT_RST     = '0
) (
    input  logic            clk,
    input  logic            reset,
    rv_gpio_if.slave        bus,
    input  logic [NBIT-1:0] pin,
    output logic [NBIT-1:0] pout,
    output logic [NBIT-1:0] poe,
    output logic            irq
);

    localparam u32_t       VALID     = width_mask(NBIT);
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    u32_t            lane_mask;
    logic            access;
    gpio_reg_e       sel;
    logic [NBIT-1:0] wmask;
    logic [NBIT-1:0] wdata;

    logic [NBIT-1:0] data_out_reg, data_out_next;
    logic [NBIT-1:0] dir_reg, dir_next;
    logic [NBIT-1:0] rise_en_reg, rise_en_next;
    logic [NBIT-1:0] fall_en_reg, fall_en_next;
    logic [NBIT-1:0] pend_reg, pend_next, pend_clr;
    logic [NBIT-1:0] sync_q, prev_reg, edge_set;
    logic [2:0]      warm_cnt_reg;
    logic            armed;
    logic [NBIT-1:0] rd_val;
    u32_t            rd_word, dr_reg, dr_next;
    logic            irq_reg;
    logic            unused_bits;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_mask[8*gi +: 8] = {8{bus.we[gi]}};
    end

    assign access = bus.cs & bus.rdy;
    assign sel    = gpio_reg_e'(bus.adr[4:2]);
    assign wmask  = lane_mask[NBIT-1:0] & {NBIT{access}};
    assign wdata  = bus.dw[NBIT-1:0];

    // Lanes/bits above NBIT and the byte offset inside a word carry no state.
    assign unused_bits = ^{bus.adr[1:0], bus.dw & ~VALID, lane_mask & ~VALID};

    always_comb begin
        data_out_next = data_out_reg;
        dir_next      = dir_reg;
        rise_en_next  = rise_en_reg;
        fall_en_next  = fall_en_reg;
        pend_clr      = '0;
        case (sel)
            GPIO_OUT:  data_out_next = (data_out_reg & ~wmask) | (wdata & wmask);
            GPIO_SET:  data_out_next = data_out_reg | (wdata & wmask);
            GPIO_CLR:  data_out_next = data_out_reg & ~(wdata & wmask);
            GPIO_DIR:  dir_next      = (dir_reg & ~wmask) | (wdata & wmask);
            GPIO_RISE: rise_en_next  = (rise_en_reg & ~wmask) | (wdata & wmask);
            GPIO_FALL: fall_en_next  = (fall_en_reg & ~wmask) | (wdata & wmask);
            GPIO_PEND: pend_clr      = wdata & wmask;
            default:   ;
        endcase
        // A fresh edge outranks a same-cycle clear so no event is lost.
        pend_next = (pend_reg & ~pend_clr) | edge_set;
    end

    rv_sync #(
        .W      (NBIT),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pin),
        .q     (sync_q)
    );

    // Masked until the synchroniser and prev flop hold real pad values.
    assign armed = (warm_cnt_reg == WARM_DONE);

    for (genvar gi = 0; gi < NBIT; gi++) begin : g_edge
        assign edge_set[gi] = armed &
            (( sync_q[gi] & ~prev_reg[gi] & rise_en_reg[gi]) |
             (~sync_q[gi] &  prev_reg[gi] & fall_en_reg[gi]));
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            GPIO_OUT:  rd_val = data_out_reg;
            GPIO_IN:   rd_val = sync_q;
            GPIO_DIR:  rd_val = dir_reg;
            GPIO_RISE: rd_val = rise_en_reg;
            GPIO_FALL: rd_val = fall_en_reg;
            GPIO_PEND: rd_val = pend_reg;
            default:   rd_val = '0;
        endcase
        rd_word              = '0;
        rd_word[NBIT-1:0]    = rd_val;
        dr_next              = (access & bus.re) ? rd_word : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg <= OUT_RST;
            dir_reg      <= '0;
            rise_en_reg  <= '0;
            fall_en_reg  <= '0;
            pend_reg     <= '0;
            prev_reg     <= '0;
            warm_cnt_reg <= '0;
            dr_reg       <= '0;
            irq_reg      <= 1'b0;
        end else begin
            data_out_reg <= data_out_next;
            dir_reg      <= dir_next;
            rise_en_reg  <= rise_en_next;
            fall_en_reg  <= fall_en_next;
            pend_reg     <= pend_next;
            prev_reg     <= sync_q;
            if (!armed) begin
                warm_cnt_reg <= warm_cnt_reg + 3'd1;
            end
            dr_reg       <= dr_next;
            irq_reg      <= |pend_reg;
        end
    end

    assign bus.dr = dr_reg;
    assign pout   = data_out_reg;
    assign poe    = dir_reg;
    assign irq    = irq_reg;

endmodule

// File: tb/tb_rv_gpio.sv
// Directed bench for rv_gpio: register table for NBIT=8/12 plus edge/reset sequences.
module tb_rv_gpio;
    import rv_gpio_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv_gpio_if bus8();
    rv_gpio_if bus12();

    logic [7:0]  pin8, pout8, poe8;
    logic        irq8;
    logic [11:0] pin12, pout12, poe12;
    logic        irq12;

    rv_gpio #(.NBIT(8), .SYNC_STAGES(2), .OUT_RST(8'h00)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8),
        .pin(pin8), .pout(pout8), .poe(poe8), .irq(irq8)
    );

    rv_gpio #(.NBIT(12), .SYNC_STAGES(2), .OUT_RST(12'h5A3)) dut12 (
        .clk(clk), .reset(reset), .bus(bus12),
        .pin(pin12), .pout(pout12), .poe(poe12), .irq(irq12)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         d12;
        bit         is_rd;
        logic [4:0] adr;
        logic [3:0] we;
        u32_t       dw;
        u32_t       exp;
        u32_t       exp_poe;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit d12, input bit is_rd, input logic [4:0] adr,
                           input logic [3:0] we, input u32_t dw, input u32_t exp,
                           input u32_t exp_poe, input string name);
        vec_t v;
        v.d12 = d12; v.is_rd = is_rd; v.adr = adr; v.we = we;
        v.dw = dw; v.exp = exp; v.exp_poe = exp_poe; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input u32_t act, input u32_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic bus_idle();
        bus8.cs = 0;  bus8.rdy = 0;  bus8.we = 0;  bus8.re = 0;  bus8.adr = 0;  bus8.dw = 0;
        bus12.cs = 0; bus12.rdy = 0; bus12.we = 0; bus12.re = 0; bus12.adr = 0; bus12.dw = 0;
    endtask

    task automatic bus_drive(input bit d12, input logic [4:0] adr, input logic [3:0] we,
                             input logic re, input u32_t dw);
        if (d12) begin
            bus12.cs = 1; bus12.rdy = 1; bus12.adr = adr; bus12.we = we; bus12.re = re; bus12.dw = dw;
        end else begin
            bus8.cs = 1;  bus8.rdy = 1;  bus8.adr = adr;  bus8.we = we;  bus8.re = re;  bus8.dw = dw;
        end
    endtask

    task automatic wr(input bit d12, input logic [4:0] adr, input logic [3:0] we, input u32_t dw);
        @(negedge clk);
        bus_drive(d12, adr, we, 1'b0, dw);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd(input bit d12, input logic [4:0] adr, output u32_t data);
        @(negedge clk);
        bus_drive(d12, adr, 4'h0, 1'b1, '0);
        @(negedge clk);
        bus_idle();
        data = d12 ? bus12.dr : bus8.dr;
    endtask

    u32_t rdata;

    initial begin
        reset = 1'b1;
        pin8  = '0;
        pin12 = '0;
        bus_idle();
        repeat (3) @(negedge clk);
        chk("rst_pout8", {24'h0, pout8}, 32'h0);
        chk("rst_poe8", {24'h0, poe8}, 32'h0);
        chk("rst_irq8", {31'h0, irq8}, 32'h0);
        chk("rst_dr8", bus8.dr, 32'h0);
        chk("rst_pout12", {20'h0, pout12}, 32'h5A3);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // d12 is_rd adr we dw exp exp_poe name
        add_vec(0, 0, 5'h00, 4'h1, 32'h0000_00A5, 32'hA5, 32'h00, "out_lane0");
        add_vec(0, 1, 5'h00, 4'h0, 32'h0,         32'hA5, 32'h00, "rd_out");
        add_vec(0, 0, 5'h08, 4'hF, 32'hFFFF_FFFF, 32'hA5, 32'hFF, "dir_all");
        add_vec(0, 1, 5'h08, 4'h0, 32'h0,         32'hFF, 32'h00, "rd_dir_trunc");
        add_vec(0, 0, 5'h00, 4'hF, 32'h0000_00A0, 32'hA0, 32'hFF, "out_a0");
        add_vec(0, 0, 5'h0C, 4'h1, 32'h0000_000F, 32'hAF, 32'hFF, "set_0f");
        add_vec(0, 0, 5'h10, 4'h1, 32'h0000_0081, 32'h2E, 32'hFF, "clr_81");
        add_vec(0, 1, 5'h0C, 4'h0, 32'h0,         32'h00, 32'h00, "rd_set_zero");
        add_vec(0, 1, 5'h10, 4'h0, 32'h0,         32'h00, 32'h00, "rd_clr_zero");
        add_vec(0, 0, 5'h00, 4'h2, 32'h0000_5500, 32'h2E, 32'hFF, "out_lane1_ign");
        add_vec(0, 0, 5'h08, 4'h0, 32'h0,         32'h2E, 32'hFF, "dir_no_lanes");
        add_vec(0, 1, 5'h02, 4'h0, 32'h0,         32'h2E, 32'h00, "rd_out_unalign");
        add_vec(0, 0, 5'h14, 4'h1, 32'h1234_5633, 32'h2E, 32'hFF, "rise_en_wr");
        add_vec(0, 1, 5'h14, 4'h0, 32'h0,         32'h33, 32'h00, "rd_rise_en");
        add_vec(0, 0, 5'h18, 4'hF, 32'hFFFF_FFC3, 32'h2E, 32'hFF, "fall_en_wr");
        add_vec(0, 1, 5'h18, 4'h0, 32'h0,         32'hC3, 32'h00, "rd_fall_en");
        add_vec(0, 1, 5'h04, 4'h0, 32'h0,         32'h00, 32'h00, "rd_in_zero");
        add_vec(0, 0, 5'h14, 4'hF, 32'h0,         32'h2E, 32'hFF, "rise_en_off");
        add_vec(0, 0, 5'h18, 4'hF, 32'h0,         32'h2E, 32'hFF, "fall_en_off");
        add_vec(1, 1, 5'h00, 4'h0, 32'h0,         32'h5A3, 32'h0, "d12_rd_rst");
        add_vec(1, 0, 5'h00, 4'hF, 32'hFFFF_FFFF, 32'hFFF, 32'h0, "d12_out_all");
        add_vec(1, 1, 5'h00, 4'h0, 32'h0,         32'hFFF, 32'h0, "d12_rd_trunc");
        add_vec(1, 0, 5'h00, 4'hF, 32'h0,         32'h000, 32'h0, "d12_out_zero");
        add_vec(1, 0, 5'h00, 4'h2, 32'hFFFF_FFFF, 32'hF00, 32'h0, "d12_lane1");
        add_vec(1, 1, 5'h00, 4'h0, 32'h0,         32'hF00, 32'h0, "d12_rd_lane1");
        add_vec(1, 0, 5'h0C, 4'h1, 32'h0000_0013, 32'hF13, 32'h0, "d12_set");
        add_vec(1, 0, 5'h10, 4'h2, 32'h0000_0F00, 32'h013, 32'h0, "d12_clr");

        foreach (vecs[i]) begin
            if (vecs[i].is_rd) begin
                rd(vecs[i].d12, vecs[i].adr, rdata);
                chk(vecs[i].name, rdata, vecs[i].exp);
            end else begin
                wr(vecs[i].d12, vecs[i].adr, vecs[i].we, vecs[i].dw);
                if (vecs[i].d12) begin
                    chk({vecs[i].name, "_pout"}, {20'h0, pout12}, vecs[i].exp);
                    chk({vecs[i].name, "_poe"}, {20'h0, poe12}, vecs[i].exp_poe);
                end else begin
                    chk({vecs[i].name, "_pout"}, {24'h0, pout8}, vecs[i].exp);
                    chk({vecs[i].name, "_poe"}, {24'h0, poe8}, vecs[i].exp_poe);
                end
            end
        end

        // Accesses without both cs and rdy must do nothing; idle dr is 0.
        @(negedge clk);
        bus8.cs = 0; bus8.rdy = 1; bus8.we = 4'hF; bus8.adr = 5'h00; bus8.dw = 32'hFF;
        @(negedge clk);
        bus8.cs = 1; bus8.rdy = 0; bus8.re = 1;
        @(negedge clk);
        bus_idle();
        chk("nosel_wr_pout", {24'h0, pout8}, 32'h2E);
        chk("norudy_rd_dr", bus8.dr, 32'h0);

        // Rising edge on bit 0: PEND 3 cycles after the pin, irq one more.
        wr(0, 5'h14, 4'h1, 32'h01);
        pin8 = 8'h01;
        repeat (3) @(negedge clk);
        chk("rise_irq_early", {31'h0, irq8}, 32'h0);
        @(negedge clk);
        chk("rise_irq_on", {31'h0, irq8}, 32'h1);
        rd(0, 5'h1C, rdata);
        chk("rise_pend", rdata, 32'h01);
        wr(0, 5'h1C, 4'h1, 32'h01);
        chk("w1c_irq_lag", {31'h0, irq8}, 32'h1);
        @(negedge clk);
        chk("w1c_irq_off", {31'h0, irq8}, 32'h0);
        rd(0, 5'h1C, rdata);
        chk("w1c_pend", rdata, 32'h00);

        // Falling edge on bit 1; disabling FALL_EN keeps PEND.
        wr(0, 5'h18, 4'h1, 32'h02);
        pin8 = 8'h03;
        repeat (4) @(negedge clk);
        pin8 = 8'h01;
        repeat (4) @(negedge clk);
        rd(0, 5'h1C, rdata);
        chk("fall_pend", rdata, 32'h02);
        wr(0, 5'h18, 4'hF, 32'h0);
        rd(0, 5'h1C, rdata);
        chk("fall_pend_kept", rdata, 32'h02);
        chk("fall_irq", {31'h0, irq8}, 32'h1);
        wr(0, 5'h1C, 4'hF, 32'hFF);
        rd(0, 5'h1C, rdata);
        chk("fall_pend_clr", rdata, 32'h00);

        // Edge set on bit 3 lands on the same edge as its W1C.
        wr(0, 5'h14, 4'h1, 32'h08);
        pin8 = 8'h09;
        @(negedge clk);
        wr(0, 5'h1C, 4'h1, 32'h08);
        rd(0, 5'h1C, rdata);
        chk("set_beats_w1c", rdata, 32'h08);

        // Reset together with a read: reset wins, all state returns to reset.
        @(negedge clk);
        bus_drive(0, 5'h00, 4'h0, 1'b1, '0);
        reset = 1'b1;
        @(negedge clk);
        bus_idle();
        chk("rst_rd_dr", bus8.dr, 32'h0);
        chk("rst2_pout8", {24'h0, pout8}, 32'h0);
        chk("rst2_poe8", {24'h0, poe8}, 32'h0);
        chk("rst2_irq8", {31'h0, irq8}, 32'h0);
        chk("rst2_pout12", {20'h0, pout12}, 32'h5A3);

        // Pins high through reset with edges enabled early: no spurious rise.
        pin8  = 8'hFF;
        pin12 = 12'hFFF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wr(0, 5'h14, 4'hF, 32'hFF);
        wr(1, 5'h14, 4'hF, 32'hFFF);
        repeat (10) @(negedge clk);
        rd(0, 5'h1C, rdata);
        chk("warm_pend8", rdata, 32'h0);
        rd(1, 5'h1C, rdata);
        chk("warm_pend12", rdata, 32'h0);
        chk("warm_irq8", {31'h0, irq8}, 32'h0);
        rd(0, 5'h04, rdata);
        chk("rd_in_ff", rdata, 32'hFF);
        rd(1, 5'h04, rdata);
        chk("d12_rd_in_fff", rdata, 32'hFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
